regfile_wb: RTL
===============

// Module: regfile_wb
// PURPOSE
//   General-purpose register file at the consumer end of the MEM/WB write-back interface.
//   - Commits WB-stage register writes with per-byte lane enables.
//   - Serves two decode-stage read ports, with same-cycle write-to-read bypass.
//   - Optionally emits a registered commit trace and a retired-write counter for debug.
// PARAMETERS
//   DATA_W  32  register width in bits; must be a multiple of 8
//   ADDR_W  5   register address width
//   NREG    32  number of registers (2**ADDR_W); register 0 is hardwired to zero
// PORTS
//   clk        in   1            clock, rising edge
//   rst        in   1            reset, synchronous, active-high
//   wb_wreg    in   DATA_W/8     byte-lane write enables; bit i covers wdata[8i+7:8i]
//   wb_wd      in   ADDR_W       write register address
//   wb_wdata   in   DATA_W       write data
//   wb_pc      in   32           PC of the instruction being written back
//   re1        in   1            read port 1 enable
//   raddr1     in   ADDR_W       read port 1 address
//   rdata1     out  DATA_W       read port 1 data (combinational)
//   re2        in   1            read port 2 enable
//   raddr2     in   ADDR_W       read port 2 address
//   rdata2     out  DATA_W       read port 2 data (combinational)
//   trace_valid  out  1          [REGFILE_TRACE_EN] commit trace strobe
//   trace_pc     out  32         [REGFILE_TRACE_EN] PC of the committed write
//   trace_wd     out  ADDR_W     [REGFILE_TRACE_EN] register written
//   trace_wdata  out  DATA_W     [REGFILE_TRACE_EN] full post-merge register value
//   commit_cnt   out  32         [REGFILE_TRACE_EN] count of accepted writes
// BEHAVIOUR
//   Write acceptance
//   - A write is accepted when rst=0, wb_wreg!=0 and wb_wd!=0.
//   - It lands on the clk edge: only lanes with wb_wreg[i]=1 are updated; other lanes keep their old value.
//   - Writes to register 0 are discarded. Register 0 always reads 0.
//   Reset
//   - While rst=1 at an edge, every register clears to 0 and no write is accepted.
//   - Reset takes effect one edge after rst rises.
//   - A write presented in the same cycle as rst=1 is lost, including when reset arrives mid-stream.
//   Reads (no clock latency)
//   - rdataN = 0 if rst=1, reNo=0, or raddrN=0.
//   - Otherwise, if the port address equals wb_wd and a write is accepted this cycle, the result is merged per lane:
//     lanes with wb_wreg[i]=1 come from wb_wdata; the remaining lanes come from the stored register.
//   - Otherwise, rdataN is the stored register value.
//   - Both ports may address the same register, or the write address, simultaneously; each bypasses independently.
//   Write timing
//   - A write is visible via bypass in its own cycle and from storage on every later cycle.
//     Decode therefore never stalls on a WB hazard.
//   Value semantics
//   - No arithmetic and no sign extension; lane data is stored verbatim.
// CONFIGURATION
//   REGFILE_TRACE_EN defined
//   - Trace ports exist. Every value below is registered and updated on each edge.
//   - trace_valid = 1 for exactly one cycle after each accepted write.
//   - trace_pc, trace_wd and trace_wdata hold that write's wb_pc, wb_wd and full merged register value.
//   - Outputs hold their values when trace_valid=0.
//   - commit_cnt increments by 1 per accepted write and wraps from 32'hFFFFFFFF to 0.
//   - rst clears trace_valid, trace_pc, trace_wd, trace_wdata and commit_cnt to 0.
//   REGFILE_TRACE_EN undefined
//   - Trace ports and their logic are absent. Storage and read behaviour are identical to the defined case.
// TESTING
//   1. Reset/zero: rst=1 for 2 cycles, then read all 32 registers on both ports -> every rdata=0.
//      Write wd=0, wreg=4'hF, wdata=32'hDEADBEEF -> raddr1=0 still reads 0; commit_cnt stays 0.
//   2. Full write and read: wd=5, wreg=4'hF, wdata=32'h12345678.
//      -> Next cycle raddr1=5 gives 32'h12345678.
//      -> With re2=0, raddr2=5 gives 0.
//   3. Byte lanes: reg 5 = 32'h12345678, then wd=5, wreg=4'b0101, wdata=32'hAABBCCDD -> reg 5 = 32'h12BB56DD.
//   4. Bypass: same cycle as step 3, raddr1=raddr2=5 -> both give 32'h12BB56DD combinationally.
//      Read of raddr1=6 while writing reg 5 -> stored value of reg 6.
//   5. Reset mid-stream: reg 7 = 32'h1. Assert rst in the same cycle as write wd=7, wdata=32'h2.
//      -> After rst drops, reg 7 = 0; rdata is 0 throughout reset.
//   6. Trace (REGFILE_TRACE_EN): write wd=9, wreg=4'hF, wdata=32'h55, wb_pc=32'hBFC00010.
//      -> Next cycle trace_valid=1, trace_pc=32'hBFC00010, trace_wd=9, trace_wdata=32'h55, commit_cnt=1.
//      Preload the counter to 32'hFFFFFFFF via force, then one more write -> commit_cnt=0.

Source files
------------

// File: rtl/regfile_wb.sv
// General-purpose register file at the MEM/WB write-back boundary: byte-lane writes,
// two bypassed combinational read ports. Optional debug trace under `REGFILE_TRACE_EN`.
module regfile_wb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREG   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W/8-1:0]   wb_wreg,
    input  logic [ADDR_W-1:0]     wb_wd,
    input  logic [DATA_W-1:0]     wb_wdata,
    input  logic [31:0]           wb_pc,
    input  logic                  re1,
    input  logic [ADDR_W-1:0]     raddr1,
    output logic [DATA_W-1:0]     rdata1,
    input  logic                  re2,
    input  logic [ADDR_W-1:0]     raddr2,
    output logic [DATA_W-1:0]     rdata2
`ifdef REGFILE_TRACE_EN
    ,
    output logic                  trace_valid,
    output logic [31:0]           trace_pc,
    output logic [ADDR_W-1:0]     trace_wd,
    output logic [DATA_W-1:0]     trace_wdata,
    output logic [31:0]           commit_cnt
`endif
);

    localparam int unsigned NLANE = DATA_W / 8;

    logic [DATA_W-1:0] regs [NREG];
    logic              write_ok_c;
    logic [DATA_W-1:0] merged_c;

    // Lane-wise merge of incoming write data over the currently stored value.
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [NLANE-1:0]  lanes
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int i = 0; i < int'(NLANE); i++) begin
            if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        write_ok_c = !rst && (wb_wreg != '0) && (wb_wd != '0);
        merged_c   = lane_merge(regs[wb_wd], wb_wdata, wb_wreg);
    end

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
        end else if (write_ok_c) begin
            regs[wb_wd] <= merged_c;
        end
    end

    // Read ports see a same-cycle write through the merge path, so decode never stalls.
    always_comb begin
        rdata1 = '0;
        if (!rst && re1 && (raddr1 != '0)) begin
            rdata1 = (write_ok_c && (raddr1 == wb_wd)) ? merged_c : regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (!rst && re2 && (raddr2 != '0)) begin
            rdata2 = (write_ok_c && (raddr2 == wb_wd)) ? merged_c : regs[raddr2];
        end
    end

`ifdef REGFILE_TRACE_EN
    // Commit trace: one-cycle strobe per accepted write, payload held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_wd    <= '0;
            trace_wdata <= '0;
            commit_cnt  <= '0;
        end else begin
            trace_valid <= write_ok_c;
            if (write_ok_c) begin
                trace_pc    <= wb_pc;
                trace_wd    <= wb_wd;
                trace_wdata <= merged_c;
                commit_cnt  <= commit_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^wb_pc;
`endif

endmodule
